tmds_channel_decoder: RTL and testbench

Receive-side counterpart of the DVI/HDMI TMDS output path. Decodes one TMDS channel per instance. Input is a raw, unaligned 10-bit word stream from the upstream deserializer, one word per pixel clock. The block finds the word boundary by hunting for control tokens with a bit-slip search, then decodes each aligned word to 8-bit pixel data or a 2-bit control value. Three instances, one per channel, feed the MIPI/frame-buffer-style video stream logic.

---
 rtl/tmds_channel_decoder.sv | 171 +++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder (receive side, one channel).
// Finds the 10-bit word boundary in an unaligned deserialized stream by hunting for
// control tokens with a bit-slip search, then decodes aligned words to 8-bit pixel
// data or a 2-bit control value.
//
// Ports:
//   iPCLK    pixel clock, rising edge
//   iRESET   asynchronous active-high reset
//   iDATA    raw 10-bit word, bit 0 is the earliest serial bit
//   oDATA    decoded pixel byte (held across control tokens)
//   oCTRL    last decoded control value {C1,C0}
//   oDE      aligned word was a data word while locked
//   oLOCKED  word alignment achieved
//   oSHIFT   current bit-slip offset, 0..9
module tmds_channel_decoder #(
  parameter int unsigned LOCK_TOKENS = 8,
  parameter int unsigned TIMEOUT     = 2048
) (
  input  logic       iPCLK,
  input  logic       iRESET,
  input  logic [9:0] iDATA,
  output logic [7:0] oDATA,
  output logic [1:0] oCTRL,
  output logic       oDE,
  output logic       oLOCKED,
  output logic [3:0] oSHIFT
);

  localparam int unsigned TokW  = $clog2(LOCK_TOKENS + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  localparam logic [TokW-1:0]  TokLast  = TokW'(LOCK_TOKENS - 1);
  localparam logic [TokW-1:0]  TokMax   = TokW'(LOCK_TOKENS);
  // A data word evaluated with this count would bring the idle count to TIMEOUT-1.
  localparam logic [IdleW-1:0] IdleSlip = IdleW'(TIMEOUT - 2);
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(TIMEOUT);

  typedef enum logic [1:0] {StSearch, StHold, StLocked} state_e;

  state_e           state_q, state_d;
  logic [9:0]       prev_q, cur_q, word_q;
  logic [TokW-1:0]  tok_q, tok_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             hold_q, hold_d;
  logic [3:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             de_q, de_d;

  logic [19:0] stream;
  logic [9:0]  aligned;
  logic        is_tok;
  logic [1:0]  tok_val;
  logic [8:0]  q;
  logic [7:0]  dec;

  assign stream  = {cur_q, prev_q};
  assign aligned = stream[shift_q +: 10];

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (word_q)
      10'b1101010100: tok_val = 2'b00;
      10'b0010101011: tok_val = 2'b01;
      10'b0101010100: tok_val = 2'b10;
      10'b1010101011: tok_val = 2'b11;
      default:        is_tok  = 1'b0;
    endcase
  end

  always_comb begin
    q      = word_q[9] ? {word_q[8], ~word_q[7:0]} : word_q[8:0];
    dec    = '0;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = q[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  // State register (FSM plus datapath registers).
  always_ff @(posedge iPCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= StSearch;
      prev_q  <= '0;
      cur_q   <= '0;
      word_q  <= '0;
      tok_q   <= '0;
      idle_q  <= '0;
      hold_q  <= 1'b0;
      shift_q <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
      de_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= cur_q;
      cur_q   <= iDATA;
      word_q  <= aligned;
      tok_q   <= tok_d;
      idle_q  <= idle_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      de_q    <= de_d;
    end
  end

  // Next-state logic: lock search, timeout slip, hold flush.
  always_comb begin
    state_d = state_q;
    tok_d   = tok_q;
    idle_d  = idle_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    unique case (state_q)
      StHold: begin
        tok_d  = '0;
        idle_d = '0;
        hold_d = 1'b1;
        if (hold_q) begin
          state_d = StSearch;
          hold_d  = 1'b0;
        end
      end
      StSearch, StLocked: begin
        if (is_tok) begin
          // A token always beats a timeout on the same cycle.
          idle_d = '0;
          tok_d  = (tok_q == TokMax) ? tok_q : tok_q + 1'b1;
          if (state_q == StSearch && tok_q == TokLast) begin
            state_d = StLocked;
          end
        end else if (idle_q == IdleSlip) begin
          state_d = StHold;
          hold_d  = 1'b0;
          tok_d   = '0;
          idle_d  = '0;
          shift_d = (shift_q == 4'd9) ? 4'd0 : shift_q + 4'd1;
        end else begin
          tok_d  = '0;
          idle_d = (idle_q == IdleMax) ? idle_q : idle_q + 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // Output-register next values; nothing is evaluated while the pipeline flushes.
  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    de_d   = 1'b0;
    if (state_q != StHold) begin
      if (is_tok) begin
        ctrl_d = tok_val;
      end else begin
        data_d = dec;
        de_d   = (state_d == StLocked);
      end
    end
  end

  assign oDATA   = data_q;
  assign oCTRL   = ctrl_q;
  assign oDE     = de_q;
  assign oLOCKED = (state_q == StLocked);
  assign oSHIFT  = shift_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: a cycle-level behavioural model of the
// receive rules is compared against the DUT on every falling edge, plus literal checks.
module tb_tmds_channel_decoder;

  localparam int unsigned LT = 8;
  localparam int unsigned TO = 64;

  localparam logic [9:0] T00 = 10'h354;
  localparam logic [9:0] T01 = 10'h0AB;
  localparam logic [9:0] T10 = 10'h154;
  localparam logic [9:0] T11 = 10'h2AB;

  localparam int MSearch = 0;
  localparam int MHold   = 1;
  localparam int MLocked = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = '0;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;
  logic       o_de;
  logic       o_locked;
  logic [3:0] o_shift;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tmds_channel_decoder #(
    .LOCK_TOKENS (LT),
    .TIMEOUT     (TO)
  ) dut (
    .iPCLK   (clk),
    .iRESET  (rst),
    .iDATA   (din),
    .oDATA   (o_data),
    .oCTRL   (o_ctrl),
    .oDE     (o_de),
    .oLOCKED (o_locked),
    .oSHIFT  (o_shift)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int tok_code(input logic [9:0] w);
    case (w)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [9:0] tok_word(input int i);
    case (i)
      0:       return T00;
      1:       return T01;
      2:       return T10;
      default: return T11;
    endcase
  endfunction

  function automatic logic [7:0] tmds_dec(input logic [9:0] w);
    logic [8:0] qq;
    logic [7:0] d;
    qq = w[8:0];
    if (w[9]) qq[7:0] = ~qq[7:0];
    d[0] = qq[0];
    for (int i = 1; i < 8; i++) d[i] = qq[i] ^ qq[i-1] ^ ~qq[8];
    return d;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'($urandom);
    if (tok_code(w) >= 0) w = w ^ 10'h001;
    return w;
  endfunction

  // ---------------- behavioural model ----------------
  logic [9:0] m_prev, m_cur, m_word;
  int         m_shift, m_mode, m_hold_left, m_streak, m_run;
  logic [7:0] m_data;
  logic [1:0] m_ctrl;
  logic       m_de;

  task automatic mreset();
    m_prev = '0; m_cur = '0; m_word = '0;
    m_shift = 0; m_mode = MSearch; m_hold_left = 0; m_streak = 0; m_run = 0;
    m_data = '0; m_ctrl = '0; m_de = 1'b0;
  endtask

  task automatic mstep();
    logic [19:0] s;
    logic [9:0]  nw;
    int          c;
    s  = {m_cur, m_prev};
    nw = 10'((s >> m_shift) & 20'h3FF);
    if (m_mode == MHold) begin
      m_de = 1'b0;
      m_hold_left--;
      if (m_hold_left == 0) m_mode = MSearch;
    end else begin
      c = tok_code(m_word);
      if (c >= 0) begin
        m_ctrl = 2'(c);
        m_de   = 1'b0;
        m_run  = 0;
        if (m_streak < int'(LT)) m_streak++;
        if (m_mode == MSearch && m_streak == int'(LT)) m_mode = MLocked;
      end else begin
        m_data   = tmds_dec(m_word);
        m_streak = 0;
        if (m_run + 1 == int'(TO) - 1) begin
          m_shift     = (m_shift + 1) % 10;
          m_mode      = MHold;
          m_hold_left = 2;
          m_run       = 0;
        end else if (m_run < int'(TO)) begin
          m_run++;
        end
        m_de = (m_mode == MLocked);
      end
    end
    m_word = nw;
    m_prev = m_cur;
    m_cur  = din;
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) mreset();
      else     mstep();
    end
  end

  always @(negedge clk) begin
    chk("cmp_data",   int'(o_data),   int'(m_data));
    chk("cmp_ctrl",   int'(o_ctrl),   int'(m_ctrl));
    chk("cmp_de",     int'(o_de),     int'(m_de));
    chk("cmp_locked", int'(o_locked), (m_mode == MLocked) ? 1 : 0);
    chk("cmp_shift",  int'(o_shift),  m_shift);
  end

  // ---------------- stimulus ----------------
  bit txq[$];

  task automatic send(input logic [9:0] w);
    din = w;
    @(negedge clk);
  endtask

  // Serial bit stream delayed by 'off' bits relative to the deserializer boundary.
  task automatic start_off(input int off);
    txq.delete();
    for (int i = 0; i < off; i++) txq.push_back(bit'($urandom_range(0, 1)));
  endtask

  task automatic send_tx(input logic [9:0] w);
    logic [9:0] raw;
    for (int j = 0; j < 10; j++) txq.push_back(w[j]);
    for (int j = 0; j < 10; j++) raw[j] = txq.pop_front();
    send(raw);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_data"},   int'(o_data),   0);
    chk({tag, "_ctrl"},   int'(o_ctrl),   0);
    chk({tag, "_de"},     int'(o_de),     0);
    chk({tag, "_locked"}, int'(o_locked), 0);
    chk({tag, "_shift"},  int'(o_shift),  0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic search(input string tag, input int exp_shift, input int exp_slips);
    int slips;
    int last;
    bit done;
    slips = 0;
    last  = int'(o_shift);
    done  = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      send_tx(T00);
      if (int'(o_shift) != last) begin
        slips++;
        last = int'(o_shift);
      end
      if (o_locked && int'(o_shift) == exp_shift) done = 1'b1;
    end
    chk({tag, "_locked"}, int'(o_locked), 1);
    chk({tag, "_shift"},  int'(o_shift),  exp_shift);
    chk({tag, "_slips"},  slips,          exp_slips);
  endtask

  initial begin
    int n;
    int m;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_data",   int'(o_data),   0);
    chk("rst_ctrl",   int'(o_ctrl),   0);
    chk("rst_de",     int'(o_de),     0);
    chk("rst_locked", int'(o_locked), 0);
    chk("rst_shift",  int'(o_shift),  0);

    // Aligned lock at offset 0.
    repeat (LT) send(T00);
    send(10'h100);
    send(10'h100);
    chk("lock_before_edge3", int'(o_locked), 0);
    send(10'h100);
    chk("lock_at_edge3",   int'(o_locked), 1);
    chk("lock_ctrl",       int'(o_ctrl),   0);
    chk("lock_shift",      int'(o_shift),  0);
    send(10'h100);
    chk("dec_100_data", int'(o_data), 8'h00);
    chk("dec_100_de",   int'(o_de),   1);

    // Data decode, then a control token holding the data byte.
    send(10'h2FF);
    repeat (3) send(T01);
    chk("dec_2ff_data", int'(o_data), 8'hFE);
    chk("dec_2ff_de",   int'(o_de),   1);
    send(T01);
    chk("tok01_ctrl", int'(o_ctrl), 1);
    chk("tok01_de",   int'(o_de),   0);
    chk("tok01_hold", int'(o_data), 8'hFE);

    // Random data while locked never drops lock.
    repeat (40) send(rand_data());
    chk("rand_data_locked", int'(o_locked), 1);
    send(T10);

    // Token on the cycle the idle count would time out keeps the lock.
    repeat (TO - 2) send(10'h100);
    send(T11);
    repeat (TO - 3) send(10'h100);
    chk("late_token_locked", int'(o_locked), 1);
    chk("late_token_shift",  int'(o_shift),  0);
    // Only data words now: lock drops and the offset advances once.
    repeat (TO) send(10'h100);
    chk("loss_locked", int'(o_locked), 0);
    chk("loss_shift",  int'(o_shift),  1);
    chk("loss_de",     int'(o_de),     0);

    pulse_reset("midrst");

    // Broken token run: 5 tokens, one data word, then 8 tokens.
    repeat (5) send(T00);
    send(10'h100);
    repeat (LT - 1) send(T00);
    send(T00);
    send(10'h100);
    send(10'h100);
    chk("broken_run_not_locked", int'(o_locked), 0);
    send(10'h100);
    chk("broken_run_locked", int'(o_locked), 1);

    // Bit-slip searches.
    pulse_reset("rst_s3");
    start_off(3);
    search("slip3", 3, 3);
    pulse_reset("rst_s9");
    start_off(9);
    search("slip9", 9, 9);
    start_off(0);
    search("wrap", 0, 1);

    // Randomized bursts of tokens and data at random offsets.
    repeat (25) begin
      start_off($urandom_range(0, 9));
      n = $urandom_range(0, 12);
      m = $urandom_range(0, 90);
      repeat (n) send_tx(tok_word($urandom_range(0, 3)));
      repeat (m) send_tx(rand_data());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
